fft_input_framer: RTL and testbench
===================================

# fft_input_framer

Upstream stage of `fft_8point`. Accepts a serial stream of complex Q1.15 samples on a valid/ready handshake and assembles them into 8-sample frames in natural order, x[0] first. Each frame is presented on the parallel `x_real_k`/`x_imag_k` ports feeding the FFT, with a frame-level valid/ready handshake. The fill buffer and the output buffer are separate, so frame k+1 fills while frame k is held.

## Interface
- `WIDTH`, 16, sample component width (Q1.15).
- `CHECK_LAST`, 1, when 1, `s_last` is checked against the frame boundary; when 0, `s_last` is ignored.

Ports:
- `clk`  input  1  single clock, rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `s_valid`  input  1  input sample valid.
- `s_ready`  output  1  framer can accept a sample.
- `s_real`, `s_imag`  input  WIDTH each  sample, signed Q1.15.
- `s_last`  input  1  marks the final sample of a frame.
- `x_real_k`, `x_imag_k` (k=0..7)  output  WIDTH each  frame to the FFT; index k = sample order within the frame.
- `frame_valid`  output  1  output frame held and valid.
- `frame_ready`  input  1  consumer takes the frame.
- `frame_err`  output  1  one-cycle pulse on a framing error.
- `frame_count`  output  16  number of delivered frames, wraps modulo 2^16.

## Operation
- Sample accept: `s_valid && s_ready` at a rising edge. Frame take: `frame_valid && frame_ready` at a rising edge.
- The fill buffer holds 8 × {real, imag}.
- `idx` is a 3-bit write index and points to the next slot.
- Accepted samples are written to slot `idx`, then `idx` increments.
- States:
  - FILL: `s_ready`=1.
  - FULL: `s_ready`=0; the fill buffer is complete and waits for the output slot.
- Output slot free at an edge means `!frame_valid || frame_ready`.
- Sample accepted at idx=7 in FILL:
  - Output slot free: the fill buffer plus this sample copy to the output registers at this edge. `frame_valid` is 1 and `frame_count` increments next cycle. State stays FILL and `idx` goes to 0.
  - Output slot not free: state goes to FULL.
- In FULL, at the first edge where the output slot is free:
  - The copy occurs.
  - `frame_valid` is 1 and `frame_count` increments.
  - State returns to FILL and `idx` goes to 0.
- Take without a new copy: `frame_valid` goes to 0. The `x_*` outputs hold their last value.
- `x_*` outputs change only on a copy edge, so they are stable while `frame_valid` is high.
- `CHECK_LAST`=1 framing checks:
  - Accepted sample with `s_last`=1 at idx<7: the partial frame is discarded, `idx` goes to 0, `frame_err` pulses, and nothing is delivered.
  - Accepted sample with `s_last`=0 at idx=7: the frame is delivered normally and `frame_err` pulses.
- No arithmetic is applied to samples. Sample bits pass through unchanged, so 0x8000 and 0x7FFF are preserved.

## Timing
- Reset (rst high at an edge):
  - State is FILL and `idx`=0.
  - All `x_*` = 0, `frame_valid`=0, `frame_err`=0, `frame_count`=0.
  - `s_ready` reads 0 while `rst` is high. It is combinational: `!rst && state==FILL`.
- Reset mid-frame discards the partial frame and any pending frame. Accepts on that edge are ignored.
- Latency: the 8th sample is accepted at edge t, and `frame_valid` with the new data is visible after edge t when the slot is free.
- Throughput: with `frame_ready` held at 1 and a continuous `s_valid`, one frame every 8 cycles with zero stalls.
- Backpressure cost: leaving FULL costs one bubble cycle. `s_ready` rises the cycle after the copy.
- `s_ready` has no combinational path from `frame_ready`.
- Simultaneous events:
  - Take and copy on the same edge: the copy wins, and `frame_valid` stays 1 with new data.
  - Error discard with `s_last` at idx<7 while in FILL: it does not touch the output slot.

## Structure
- Shared package `fft_pkg` holds:
  - `FFT_N`=8, `FFT_LOG2N`=3, `SAMPLE_W`=16.
  - The complex sample typedef {real, imag}.
  - The state enum {FILL, FULL}.
- `fft_pkg` is also imported by `fft_8point` and its bench.
- One sub-module: `fft_frame_buf`, an 8-entry complex register file with an indexed write port and a parallel read port.
- The top level contains the FSM, the handshakes, the output registers and the counters.

## Test plan
- Reset then impulse: stream 0x7FFF followed by 7 zeros (imag 0), `s_last` on the 8th, `frame_ready`=1 → `frame_valid` after the 8th accept; `x_real_0`=0x7FFF, all others 0; `frame_count`=1.
- Back-to-back: 3 frames of constant 0x1000, then a frame of 7FFF,0000,8000,0000,7FFF,0000,8000,0000 → `s_ready` is never low; frames arrive 8 cycles apart; last frame bit-exact, 0x8000 preserved; `frame_count`=4.
- Backpressure: `frame_ready`=0 while 16 samples are offered → first frame held unchanged; `s_ready` drops after the 16th accept. Raise `frame_ready` → second frame appears; `s_ready` returns one cycle after the copy.
- Early `s_last` on the 4th sample → `frame_err` pulses once and no frame is delivered. The next 8 samples form a correct frame with `x_real_0` = the 5th sample.
- Reset asserted after 5 samples, with a frame pending → all outputs return to their reset values. A subsequent clean frame is delivered and `frame_count`=1.
- `CHECK_LAST`=0 with random `s_last` → no `frame_err`; frames are cut strictly every 8 samples.

Source files
------------

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants and types for the 8-point FFT datapath
// Contents: transform size constants, complex sample type, framer state enum.
package fft_pkg;

    localparam int FFT_N     = 8;
    localparam int FFT_LOG2N = 3;
    localparam int SAMPLE_W  = 16;

    // Complex Q1.15 sample; 'real' is a keyword, hence re/im.
    typedef struct packed {
        logic signed [SAMPLE_W-1:0] re;
        logic signed [SAMPLE_W-1:0] im;
    } cplx_t;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } frame_state_t;

endpackage

// File: rtl/fft_frame_buf.sv
// rtl/fft_frame_buf.sv - 8-entry complex register file, indexed write, parallel read
// Ports:
//   clk               rising-edge clock
//   we, waddr         write enable and slot index
//   wr_real, wr_imag  sample written to slot waddr
//   rd_real, rd_imag  all FFT_N slots, slot k at index k
module fft_frame_buf
    import fft_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [FFT_LOG2N-1:0]          waddr,
    input  logic [WIDTH-1:0]              wr_real,
    input  logic [WIDTH-1:0]              wr_imag,
    output logic [FFT_N-1:0][WIDTH-1:0]   rd_real,
    output logic [FFT_N-1:0][WIDTH-1:0]   rd_imag
);

    logic [FFT_N-1:0][WIDTH-1:0] mem_re;
    logic [FFT_N-1:0][WIDTH-1:0] mem_im;

    // Pure datapath storage: contents are only observed after a full fill,
    // so no reset is needed.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_re[waddr] <= wr_real;
            mem_im[waddr] <= wr_imag;
        end
    end

    assign rd_real = mem_re;
    assign rd_imag = mem_im;

endmodule

// File: rtl/fft_input_framer.sv
// rtl/fft_input_framer.sv - serial complex sample stream to 8-sample parallel frames
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   s_valid/s_ready/s_real/s_imag/s_last   input sample handshake
//   x_real_k/x_imag_k (k=0..7)      held output frame, k = sample order
//   frame_valid/frame_ready         output frame handshake
//   frame_err                       one-cycle pulse on a framing error
//   frame_count                     delivered frames, wraps at 2^16
module fft_input_framer
    import fft_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter bit CHECK_LAST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_real,
    input  logic [WIDTH-1:0] s_imag,
    input  logic             s_last,
    output logic [WIDTH-1:0] x_real_0,
    output logic [WIDTH-1:0] x_real_1,
    output logic [WIDTH-1:0] x_real_2,
    output logic [WIDTH-1:0] x_real_3,
    output logic [WIDTH-1:0] x_real_4,
    output logic [WIDTH-1:0] x_real_5,
    output logic [WIDTH-1:0] x_real_6,
    output logic [WIDTH-1:0] x_real_7,
    output logic [WIDTH-1:0] x_imag_0,
    output logic [WIDTH-1:0] x_imag_1,
    output logic [WIDTH-1:0] x_imag_2,
    output logic [WIDTH-1:0] x_imag_3,
    output logic [WIDTH-1:0] x_imag_4,
    output logic [WIDTH-1:0] x_imag_5,
    output logic [WIDTH-1:0] x_imag_6,
    output logic [WIDTH-1:0] x_imag_7,
    output logic             frame_valid,
    input  logic             frame_ready,
    output logic             frame_err,
    output logic [15:0]      frame_count
);

    frame_state_t               state, state_next;
    logic [FFT_LOG2N-1:0]       idx, idx_next;
    logic                       accept, slot_free, at_last;
    logic                       wr_en, copy, copy_from_input, err_next;
    logic [FFT_N-1:0][WIDTH-1:0] buf_re, buf_im;
    logic [FFT_N-1:0][WIDTH-1:0] out_re, out_im;

    fft_frame_buf #(.WIDTH(WIDTH)) u_buf (
        .clk     (clk),
        .we      (wr_en),
        .waddr   (idx),
        .wr_real (s_real),
        .wr_imag (s_imag),
        .rd_real (buf_re),
        .rd_imag (buf_im)
    );

    // Depends only on rst and state, never on frame_ready.
    assign s_ready   = !rst && (state == FILL);
    assign accept    = s_valid && s_ready;
    assign slot_free = !frame_valid || frame_ready;
    assign at_last   = (idx == FFT_LOG2N'(FFT_N - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    always_comb begin
        state_next      = state;
        idx_next        = idx;
        wr_en           = 1'b0;
        copy            = 1'b0;
        copy_from_input = 1'b0;
        err_next        = 1'b0;
        case (state)
            FILL: begin
                if (accept) begin
                    if (at_last) begin
                        // Slot 7 is written even when copying directly so that
                        // the FULL path can later copy it from the buffer.
                        wr_en    = 1'b1;
                        err_next = CHECK_LAST && !s_last;
                        idx_next = '0;
                        if (slot_free) begin
                            copy            = 1'b1;
                            copy_from_input = 1'b1;
                        end else begin
                            state_next = FULL;
                        end
                    end else if (CHECK_LAST && s_last) begin
                        err_next = 1'b1;
                        idx_next = '0;
                    end else begin
                        wr_en    = 1'b1;
                        idx_next = idx + 1'b1;
                    end
                end
            end
            FULL: begin
                if (slot_free) begin
                    copy       = 1'b1;
                    state_next = FILL;
                    idx_next   = '0;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_re      <= '0;
            out_im      <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_err <= err_next;
            if (copy) begin
                // A copy wins over a simultaneous take: valid stays high.
                out_re      <= buf_re;
                out_im      <= buf_im;
                if (copy_from_input) begin
                    out_re[FFT_N-1] <= s_real;
                    out_im[FFT_N-1] <= s_imag;
                end
                frame_valid <= 1'b1;
                frame_count <= frame_count + 16'd1;
            end else if (frame_ready) begin
                frame_valid <= 1'b0;
            end
        end
    end

    assign x_real_0 = out_re[0];
    assign x_real_1 = out_re[1];
    assign x_real_2 = out_re[2];
    assign x_real_3 = out_re[3];
    assign x_real_4 = out_re[4];
    assign x_real_5 = out_re[5];
    assign x_real_6 = out_re[6];
    assign x_real_7 = out_re[7];
    assign x_imag_0 = out_im[0];
    assign x_imag_1 = out_im[1];
    assign x_imag_2 = out_im[2];
    assign x_imag_3 = out_im[3];
    assign x_imag_4 = out_im[4];
    assign x_imag_5 = out_im[5];
    assign x_imag_6 = out_im[6];
    assign x_imag_7 = out_im[7];

endmodule

// File: tb/tb_fft_input_framer.sv
// tb/tb_fft_input_framer.sv - self-checking bench for fft_input_framer
module tb_fft_input_framer;
    import fft_pkg::*;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst, s_valid, s_last, frame_ready;
    logic [W-1:0] s_real, s_imag;

    logic s_ready, frame_valid, frame_err;
    logic [15:0] frame_count;
    logic [7:0][W-1:0] xr, xi;

    logic s_ready0, frame_valid0, frame_err0;
    logic [15:0] frame_count0;
    logic [7:0][W-1:0] xr0, xi0;

    always #5 clk = ~clk;

    fft_input_framer #(.WIDTH(W), .CHECK_LAST(1'b1)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_real(s_real), .s_imag(s_imag), .s_last(s_last),
        .x_real_0(xr[0]), .x_real_1(xr[1]), .x_real_2(xr[2]), .x_real_3(xr[3]),
        .x_real_4(xr[4]), .x_real_5(xr[5]), .x_real_6(xr[6]), .x_real_7(xr[7]),
        .x_imag_0(xi[0]), .x_imag_1(xi[1]), .x_imag_2(xi[2]), .x_imag_3(xi[3]),
        .x_imag_4(xi[4]), .x_imag_5(xi[5]), .x_imag_6(xi[6]), .x_imag_7(xi[7]),
        .frame_valid(frame_valid), .frame_ready(frame_ready),
        .frame_err(frame_err), .frame_count(frame_count)
    );

    fft_input_framer #(.WIDTH(W), .CHECK_LAST(1'b0)) dut0 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready0),
        .s_real(s_real), .s_imag(s_imag), .s_last(s_last),
        .x_real_0(xr0[0]), .x_real_1(xr0[1]), .x_real_2(xr0[2]), .x_real_3(xr0[3]),
        .x_real_4(xr0[4]), .x_real_5(xr0[5]), .x_real_6(xr0[6]), .x_real_7(xr0[7]),
        .x_imag_0(xi0[0]), .x_imag_1(xi0[1]), .x_imag_2(xi0[2]), .x_imag_3(xi0[3]),
        .x_imag_4(xi0[4]), .x_imag_5(xi0[5]), .x_imag_6(xi0[6]), .x_imag_7(xi0[7]),
        .frame_valid(frame_valid0), .frame_ready(frame_ready),
        .frame_err(frame_err0), .frame_count(frame_count0)
    );

    typedef struct packed {
        logic [7:0][W-1:0] re;
        logic [7:0][W-1:0] im;
    } frm_t;

    typedef struct {
        logic         v;
        logic [W-1:0] re;
        logic [W-1:0] im;
        logic         last;
        logic         fr;
        logic         exp_fv;
        logic         exp_err;
    } vec_t;

    // Reference model: samples collect in a partial list; 8 of them make a frame.
    frm_t         q1[$], q0[$];
    logic [W-1:0] p1r[$], p1i[$], p0r[$], p0i[$];
    int           nfr1, nfr0;
    int           nvec, nfail;
    vec_t         tbl[20];
    logic [7:0][W-1:0] held;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        q1.delete(); q0.delete();
        p1r.delete(); p1i.delete(); p0r.delete(); p0i.delete();
        nfr1 = 0; nfr0 = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; s_valid = 1'b1; s_real = 16'h5555; s_imag = 16'haaaa;
        s_last = 1'b0; frame_ready = 1'b0;
        #1;
        chk("rst_s_ready", s_ready, 0);
        @(posedge clk); @(negedge clk);
        chk("rst_frame_valid", frame_valid, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_x_real", xr, 0);
        chk("rst_x_imag", xi, 0);
        rst = 1'b0; s_valid = 1'b0;
        model_clear();
        #1;
    endtask

    // One clock: drive inputs, update the model with what the edge will do,
    // compare any frame taken, then check the error pulse after the edge.
    task automatic cycle(input logic v, input logic [W-1:0] re, input logic [W-1:0] im,
                         input logic last, input logic fr);
        logic acc1, acc0, tk1, tk0, e1;
        frm_t f;
        s_valid = v; s_real = re; s_imag = im; s_last = last; frame_ready = fr;
        #1;
        acc1 = v && s_ready;
        acc0 = v && s_ready0;
        tk1  = frame_valid && fr;
        tk0  = frame_valid0 && fr;
        if (tk1) begin
            if (q1.size() == 0) begin
                nvec++; nfail++;
                $display("FAIL frame_unexpected: got frame %0h expected none", xr);
            end else begin
                f = q1.pop_front();
                chk("frame_real", xr, f.re);
                chk("frame_imag", xi, f.im);
            end
        end
        if (tk0) begin
            if (q0.size() == 0) begin
                nvec++; nfail++;
                $display("FAIL frame0_unexpected: got frame %0h expected none", xr0);
            end else begin
                f = q0.pop_front();
                chk("frame0_real", xr0, f.re);
                chk("frame0_imag", xi0, f.im);
            end
        end
        e1 = 1'b0;
        if (acc1) begin
            p1r.push_back(re); p1i.push_back(im);
            if (p1r.size() == 8) begin
                for (int k = 0; k < 8; k++) begin f.re[k] = p1r[k]; f.im[k] = p1i[k]; end
                q1.push_back(f); nfr1++;
                e1 = !last;
                p1r.delete(); p1i.delete();
            end else if (last) begin
                e1 = 1'b1;
                p1r.delete(); p1i.delete();
            end
        end
        if (acc0) begin
            p0r.push_back(re); p0i.push_back(im);
            if (p0r.size() == 8) begin
                for (int k = 0; k < 8; k++) begin f.re[k] = p0r[k]; f.im[k] = p0i[k]; end
                q0.push_back(f); nfr0++;
                p0r.delete(); p0i.delete();
            end
        end
        @(posedge clk); @(negedge clk);
        chk("frame_err", frame_err, e1);
        chk("frame_err_nocheck", frame_err0, 0);
    endtask

    initial begin
        logic [W-1:0] r;
        logic lst;
        nvec = 0; nfail = 0;
        model_clear();
        rst = 1'b1; s_valid = 1'b0; s_real = '0; s_imag = '0; s_last = 1'b0; frame_ready = 1'b0;
        @(negedge clk);

        // Table: impulse frame, early s_last discard, then a clean frame.
        for (int k = 0; k < 20; k++) begin
            tbl[k].v  = 1'b1;
            tbl[k].fr = 1'b1;
            if (k < 8) begin
                tbl[k].re = (k == 0) ? 16'h7fff : 16'h0000;
                tbl[k].im = 16'h0000;
                tbl[k].last = (k == 7); tbl[k].exp_fv = (k == 7); tbl[k].exp_err = 1'b0;
            end else if (k < 12) begin
                tbl[k].re = 16'h0100 + 16'(k); tbl[k].im = 16'h0f00 + 16'(k);
                tbl[k].last = (k == 11); tbl[k].exp_fv = 1'b0; tbl[k].exp_err = (k == 11);
            end else begin
                tbl[k].re = 16'h0200 + 16'(k - 12); tbl[k].im = 16'hf000 - 16'(k);
                tbl[k].last = (k == 19); tbl[k].exp_fv = (k == 19); tbl[k].exp_err = 1'b0;
            end
        end
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cycle(tbl[i].v, tbl[i].re, tbl[i].im, tbl[i].last, tbl[i].fr);
            chk("tbl_frame_valid", frame_valid, tbl[i].exp_fv);
            chk("tbl_frame_err", frame_err, tbl[i].exp_err);
            if (i == 7) begin
                chk("impulse_x0", xr[0], 16'h7fff);
                chk("impulse_rest", xr[7:1], 0);
                chk("impulse_imag", xi, 0);
                chk("impulse_count", frame_count, 1);
            end
        end
        chk("early_last_x0", xr[0], 16'h0200);
        chk("early_last_count", frame_count, 2);
        cycle(1'b0, 0, 0, 1'b0, 1'b1);

        // Back-to-back with frame_ready high: no stalls, one frame per 8 cycles.
        do_reset();
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < 8; k++) begin
                if (f < 3) r = 16'h1000;
                else r = (k % 2 == 1) ? 16'h0000 : ((k % 4 == 0) ? 16'h7fff : 16'h8000);
                chk("b2b_s_ready", s_ready, 1);
                cycle(1'b1, r, (f < 3) ? 16'h1000 : 16'h0000, k == 7, 1'b1);
                chk("b2b_frame_valid", frame_valid, k == 7);
            end
        end
        chk("b2b_x2", xr[2], 16'h8000);
        chk("b2b_count", frame_count, 4);
        cycle(1'b0, 0, 0, 1'b0, 1'b1);

        // Backpressure: 16 samples with frame_ready low, then release.
        do_reset();
        for (int n = 0; n < 16; n++) begin
            chk("bp_s_ready", s_ready, 1);
            cycle(1'b1, 16'($urandom), 16'($urandom), n % 8 == 7, 1'b0);
            if (n == 7) held = xr;
        end
        chk("bp_s_ready_full", s_ready, 0);
        chk("bp_valid_held", frame_valid, 1);
        for (int n = 0; n < 3; n++) begin
            cycle(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0);
            chk("bp_x_stable", xr, held);
            chk("bp_s_ready_low", s_ready, 0);
        end
        cycle(1'b0, 0, 0, 1'b0, 1'b1);
        chk("bp_valid_after_copy", frame_valid, 1);
        chk("bp_s_ready_back", s_ready, 1);
        cycle(1'b0, 0, 0, 1'b0, 1'b1);
        chk("bp_count", frame_count, 2);
        chk("bp_drained", q1.size(), 0);

        // Reset mid-frame with a frame pending.
        do_reset();
        for (int n = 0; n < 13; n++)
            cycle(1'b1, 16'h0a00 + 16'(n), 16'h0b00 + 16'(n), n == 7, 1'b0);
        chk("mid_pending", frame_valid, 1);
        do_reset();
        for (int n = 0; n < 8; n++)
            cycle(1'b1, 16'h0c00 + 16'(n), 16'h0d00 + 16'(n), n == 7, 1'b1);
        cycle(1'b0, 0, 0, 1'b0, 1'b1);
        chk("mid_clean_count", frame_count, 1);

        // Random traffic; dut0 sees random s_last, dut mostly correct framing.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            lst = (p1r.size() == 7);
            if ($urandom_range(0, 15) == 0) lst = !lst;
            if ($urandom_range(0, 3) == 0) lst = 1'($urandom);
            case ($urandom_range(0, 5))
                0: r = 16'h8000;
                1: r = 16'h7fff;
                default: r = 16'($urandom);
            endcase
            cycle($urandom_range(0, 3) != 0, r, 16'($urandom), lst, $urandom_range(0, 2) != 0);
        end
        for (int n = 0; n < 20; n++) cycle(1'b0, 0, 0, 1'b0, 1'b1);
        chk("rand_drain", q1.size(), 0);
        chk("rand_drain0", q0.size(), 0);
        chk("rand_count", frame_count, 16'(nfr1));
        chk("rand_count0", frame_count0, 16'(nfr0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
